// File: rtl/pc_unit_pkg.sv
// Shared constants for the fetch-PC generator: default vectors and the
// sequential fetch increment.
package pc_unit_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
    localparam int          INSTR_BYTES      = 4;

endpackage : pc_unit_pkg

// File: rtl/pc_unit_if.sv
// Fetch-side bundle between the pipeline control (master) and the PC unit
// (slave): hazard/redirect/trap controls, BTB resolution feedback, and the
// fetch address plus prediction returned to IF.
interface pc_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  load_use_flag;
    logic                  if_ready;
    logic                  redirect_en;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  trap_req;
    logic                  upd_en;
    logic [DATA_WIDTH-1:0] upd_pc;
    logic                  upd_taken;
    logic [DATA_WIDTH-1:0] upd_target;
    logic [DATA_WIDTH-1:0] pc;
    logic                  if_valid;
    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;

    modport master (
        output load_use_flag, if_ready, redirect_en, redirect_pc, trap_req,
               upd_en, upd_pc, upd_taken, upd_target,
        input  pc, if_valid, pred_taken, pred_target
    );

    modport slave (
        input  load_use_flag, if_ready, redirect_en, redirect_pc, trap_req,
               upd_en, upd_pc, upd_taken, upd_target,
        output pc, if_valid, pred_taken, pred_target
    );

endinterface : pc_unit_if

// File: rtl/pc_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// synchronous update from EX resolution. Word-aligned targets are stored
// without their two zero LSBs.
module pc_unit_btb
    import pc_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] lookup_pc,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] target,
    input  logic                  upd_en,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [DATA_WIDTH-1:0] upd_target
);

    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = DATA_WIDTH - IDX - 2;

    logic [BTB_ENTRIES-1:0] valid_r;
    logic [TW-1:0]          tag_r [BTB_ENTRIES];
    logic [DATA_WIDTH-3:0]  tgt_r [BTB_ENTRIES];

    logic [IDX-1:0] lk_idx_s;
    logic [TW-1:0]  lk_tag_s;
    logic [IDX-1:0] up_idx_s;
    logic [TW-1:0]  up_tag_s;
    logic           unused_s;

    assign lk_idx_s = lookup_pc[IDX+1:2];
    assign lk_tag_s = lookup_pc[DATA_WIDTH-1:IDX+2];
    assign up_idx_s = upd_pc[IDX+1:2];
    assign up_tag_s = upd_pc[DATA_WIDTH-1:IDX+2];
    assign unused_s = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    // Lookup reads the registered contents, so a same-cycle update is not visible yet.
    always_comb begin
        hit    = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
        target = '0;
        if (hit) begin
            target = {tgt_r[lk_idx_s], 2'b00};
        end else begin
            target = '0;
        end
    end

    // Valid bits: cleared together on reset; taken sets, not-taken clears only on tag match.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (upd_en) begin
            if (upd_taken) begin
                valid_r[up_idx_s] <= 1'b1;
            end else if (tag_r[up_idx_s] == up_tag_s) begin
                valid_r[up_idx_s] <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag/target payload: a taken update overwrites whatever aliased into the slot.
    always_ff @(posedge clk) begin
        if (rst_n && upd_en && upd_taken) begin
            tag_r[up_idx_s] <= up_tag_s;
            tgt_r[up_idx_s] <= upd_target[DATA_WIDTH-1:2];
        end
    end

endmodule : pc_unit_btb

// File: rtl/pc_unit.sv
// Fetch-PC generator for the 5-stage pipeline: PC register with reset/trap
// vectors, EX redirect, load-use stall, imem handshake hold and BTB-driven
// next-PC prediction.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(RESET_VECTOR_DEF),
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = DATA_WIDTH'(TRAP_VECTOR_DEF),
    parameter int                    BTB_ENTRIES  = 16
) (
    input logic        clk,
    input logic        rst_n,
    pc_unit_if.slave   bus
);

    logic [DATA_WIDTH-1:0] pc_r;
    logic                  if_valid_r;
    logic [DATA_WIDTH-1:0] pc_next_s;
    logic                  hit_s;
    logic [DATA_WIDTH-1:0] hit_target_s;
    logic                  unused_s;

    assign unused_s = ^bus.redirect_pc[1:0];

    pc_unit_btb #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_pc  (pc_r),
        .hit        (hit_s),
        .target     (hit_target_s),
        .upd_en     (bus.upd_en),
        .upd_pc     (bus.upd_pc),
        .upd_taken  (bus.upd_taken),
        .upd_target (bus.upd_target)
    );

    // Next-PC priority: trap, redirect, load-use hold, imem-not-ready hold, prediction, sequential.
    always_comb begin
        pc_next_s = pc_r;
        if (bus.trap_req) begin
            pc_next_s = TRAP_VECTOR;
        end else if (bus.redirect_en) begin
            pc_next_s = {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
        end else if (bus.load_use_flag) begin
            pc_next_s = pc_r;
        end else if (!bus.if_ready) begin
            pc_next_s = pc_r;
        end else if (hit_s) begin
            pc_next_s = hit_target_s;
        end else begin
            pc_next_s = pc_r + DATA_WIDTH'(INSTR_BYTES);
        end
    end

    // PC register: first edge out of reset only raises if_valid so the reset vector is fetched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r       <= RESET_VECTOR;
            if_valid_r <= 1'b0;
        end else if (!if_valid_r) begin
            pc_r       <= pc_r;
            if_valid_r <= 1'b1;
        end else begin
            pc_r       <= pc_next_s;
            if_valid_r <= 1'b1;
        end
    end

    assign bus.pc          = pc_r;
    assign bus.if_valid    = if_valid_r;
    assign bus.pred_taken  = hit_s;
    assign bus.pred_target = hit_target_s;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expectations are queued when stimulus is set up
// and popped/compared once the DUT has responded.
module tb_pc_unit;
    import pc_unit_pkg::*;

    localparam int DW = 32;
    localparam int K_PC = 0;
    localparam int K_VALID = 1;
    localparam int K_PTAKEN = 2;
    localparam int K_PTGT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pc_unit_if #(.DATA_WIDTH(DW)) bus ();

    pc_unit #(
        .DATA_WIDTH   (DW),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100),
        .BTB_ENTRIES  (16)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string         tag;
        int            kind;
        logic [DW-1:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   passed = 0;

    task automatic exp_v(input string tag, input int kind, input logic [DW-1:0] val);
        exp_t e;
        e.tag = tag;
        e.kind = kind;
        e.val = val;
        sb_q.push_back(e);
    endtask

    function automatic logic [DW-1:0] observe(input int kind);
        case (kind)
            K_PC:     return bus.pc;
            K_VALID:  return DW'(bus.if_valid);
            K_PTAKEN: return DW'(bus.pred_taken);
            K_PTGT:   return bus.pred_target;
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        logic [DW-1:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            obs = observe(e.kind);
            total++;
            assert (obs === e.val) passed++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    task automatic idle();
        bus.load_use_flag = 1'b0;
        bus.if_ready      = 1'b1;
        bus.redirect_en   = 1'b0;
        bus.redirect_pc   = 32'h0;
        bus.trap_req      = 1'b0;
        bus.upd_en        = 1'b0;
        bus.upd_pc        = 32'h0;
        bus.upd_taken     = 1'b0;
        bus.upd_target    = 32'h0;
    endtask

    task automatic redirect_to(input string tag, input logic [DW-1:0] a);
        bus.redirect_en = 1'b1;
        bus.redirect_pc = a;
        exp_v(tag, K_PC, {a[DW-1:2], 2'b00});
        tick();
        idle();
    endtask

    task automatic check_pred(input string tag, input logic taken, input logic [DW-1:0] tgt);
        exp_v({tag, "_taken"}, K_PTAKEN, DW'(taken));
        exp_v({tag, "_tgt"}, K_PTGT, tgt);
        drain();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        exp_v("rst_pc", K_PC, 32'h0);
        exp_v("rst_valid", K_VALID, 32'h0);
        tick();

        // Release: valid rises, reset vector held one edge, then sequential
        rst_n = 1'b1;
        exp_v("rel_pc", K_PC, 32'h0);
        exp_v("rel_valid", K_VALID, 32'h1);
        tick();
        exp_v("seq4", K_PC, 32'h4);
        tick();
        exp_v("seq8", K_PC, 32'h8);
        tick();

        // Load-use stall for two edges
        bus.load_use_flag = 1'b1;
        exp_v("stall1", K_PC, 32'h8);
        tick();
        exp_v("stall2", K_PC, 32'h8);
        tick();
        bus.load_use_flag = 1'b0;
        exp_v("after_stall", K_PC, 32'hC);
        tick();

        // imem not ready holds the request
        bus.if_ready = 1'b0;
        exp_v("ifready_hold", K_PC, 32'hC);
        exp_v("ifready_valid", K_VALID, 32'h1);
        tick();
        bus.if_ready = 1'b1;
        exp_v("ifready_go", K_PC, 32'h10);
        tick();

        // Redirect beats stall and !if_ready; trap beats redirect
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h43;
        bus.load_use_flag = 1'b1;
        bus.if_ready = 1'b0;
        exp_v("redir_align", K_PC, 32'h40);
        tick();
        bus.trap_req = 1'b1;
        exp_v("trap_wins", K_PC, 32'h100);
        tick();
        idle();

        // Train 0x10 -> 0x80
        bus.upd_en = 1'b1;
        bus.upd_pc = 32'h10;
        bus.upd_taken = 1'b1;
        bus.upd_target = 32'h80;
        exp_v("train_seq", K_PC, 32'h104);
        tick();
        idle();
        redirect_to("go10", 32'h10);
        check_pred("hit10", 1'b1, 32'h80);
        exp_v("pred_follow", K_PC, 32'h80);
        tick();
        check_pred("miss80", 1'b0, 32'h0);

        // Alias 0x50 -> 0x20 overwrites index 4
        bus.upd_en = 1'b1;
        bus.upd_pc = 32'h50;
        bus.upd_taken = 1'b1;
        bus.upd_target = 32'h20;
        exp_v("alias_seq", K_PC, 32'h84);
        tick();
        idle();
        redirect_to("go10b", 32'h10);
        check_pred("alias_miss10", 1'b0, 32'h0);
        exp_v("alias_seq14", K_PC, 32'h14);
        tick();

        // Not-taken 0x90 on same index, tag differs: 0x50 entry stays
        bus.upd_en = 1'b1;
        bus.upd_pc = 32'h90;
        bus.upd_taken = 1'b0;
        exp_v("nt_seq", K_PC, 32'h18);
        tick();
        idle();
        redirect_to("go50", 32'h50);
        check_pred("hit50", 1'b1, 32'h20);
        exp_v("pred50", K_PC, 32'h20);
        tick();

        // Same-cycle lookup and taken update of 0x10
        redirect_to("go10c", 32'h10);
        check_pred("same_miss", 1'b0, 32'h0);
        bus.upd_en = 1'b1;
        bus.upd_pc = 32'h10;
        bus.upd_taken = 1'b1;
        bus.upd_target = 32'h80;
        exp_v("same_seq", K_PC, 32'h14);
        tick();
        idle();
        redirect_to("go10d", 32'h10);
        check_pred("next_hit", 1'b1, 32'h80);
        exp_v("next_follow", K_PC, 32'h80);
        tick();

        // Wrap at top of address space
        redirect_to("go_top", 32'hFFFF_FFFC);
        check_pred("top_miss", 1'b0, 32'h0);
        exp_v("wrap", K_PC, 32'h0);
        tick();

        // Reset mid-stream discards in-flight redirect/stall/update and clears BTB
        rst_n = 1'b0;
        bus.load_use_flag = 1'b1;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 32'h44;
        bus.upd_en = 1'b1;
        bus.upd_pc = 32'h30;
        bus.upd_taken = 1'b1;
        bus.upd_target = 32'h200;
        exp_v("mrst_pc", K_PC, 32'h0);
        exp_v("mrst_valid", K_VALID, 32'h0);
        tick();
        idle();
        rst_n = 1'b1;
        exp_v("mrel_pc", K_PC, 32'h0);
        exp_v("mrel_valid", K_VALID, 32'h1);
        tick();
        redirect_to("go10e", 32'h10);
        check_pred("cleared10", 1'b0, 32'h0);
        redirect_to("go30", 32'h30);
        check_pred("discard30", 1'b0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_pc_unit
